// File: rtl/mux_41_pkg.sv
// Shared types and constants for the 4:1 multiplexer slice.
// The select type and code names are shared by the interface, the core and the top.
package mux_41_pkg;

  typedef logic [1:0] mux41_sel_t;

  localparam mux41_sel_t SEL_I0 = 2'd0;
  localparam mux41_sel_t SEL_I1 = 2'd1;
  localparam mux41_sel_t SEL_I2 = 2'd2;
  localparam mux41_sel_t SEL_I3 = 2'd3;

endpackage : mux_41_pkg

// File: rtl/mux_41_if.sv
// Bundle of the data, select, enable and result signals of mux_41.
// master drives the inputs and observes results; slave is the multiplexer side.
interface mux_41_if
  import mux_41_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] i2;
  logic [WIDTH-1:0] i3;
  mux41_sel_t       sel;
  logic             en;
  logic [WIDTH-1:0] o_comb;
  logic [WIDTH-1:0] o;
  logic             o_valid;

  modport master (
    output i0, i1, i2, i3, sel, en,
    input  o_comb, o, o_valid
  );

  modport slave (
    input  i0, i1, i2, i3, sel, en,
    output o_comb, o, o_valid
  );

endinterface : mux_41_if

// File: rtl/mux_41_core.sv
// Combinational 4:1 selector; an unknown select propagates as all-X instead
// of silently picking an input, so select bugs stay visible in simulation.
module mux_41_core
  import mux_41_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  mux41_sel_t       sel,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] y_s;

  // select one of the four inputs
  always_comb begin
    y_s = {WIDTH{1'bx}};
    case (sel)
      SEL_I0:  y_s = i0;
      SEL_I1:  y_s = i1;
      SEL_I2:  y_s = i2;
      SEL_I3:  y_s = i3;
      default: y_s = {WIDTH{1'bx}};
    endcase
  end

  assign y = y_s;

endmodule : mux_41_core

// File: rtl/mux_41.sv
// Parameterised 4:1 multiplexer with a zero-latency output and an
// enable-gated registered copy plus a valid flag cleared by reset.
module mux_41
  import mux_41_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic    clk,
  input  logic    rst_n,
  mux_41_if.slave bus
);

  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] o_r;
  logic             valid_r;

  mux_41_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i0  (bus.i0),
    .i1  (bus.i1),
    .i2  (bus.i2),
    .i3  (bus.i3),
    .sel (bus.sel),
    .y   (sel_s)
  );

  // output register: reset dominates enable, valid sticks until the next reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_r     <= RESET_VAL;
      valid_r <= 1'b0;
    end else if (bus.en) begin
      o_r     <= sel_s;
      valid_r <= 1'b1;
    end else begin
      o_r     <= o_r;
      valid_r <= valid_r;
    end
  end

  assign bus.o_comb  = sel_s;
  assign bus.o       = o_r;
  assign bus.o_valid = valid_r;

endmodule : mux_41

// File: tb/tb_mux_41.sv
// Directed bench for mux_41: a WIDTH=1 instance for the reset/sweep sequence
// and a WIDTH=8 instance (non-zero RESET_VAL) for the vector table and toggle run.
module tb_mux_41;
  import mux_41_pkg::*;

  localparam logic [7:0] RV8 = 8'hA5;

  logic clk;
  logic rst1_n;
  logic rst8_n;
  int   tests;
  int   fails;

  mux_41_if #(.WIDTH(1)) if1 ();
  mux_41_if #(.WIDTH(8)) if8 ();

  mux_41 #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1.slave));
  mux_41 #(.WIDTH(8), .RESET_VAL(RV8))  dut8 (.clk(clk), .rst_n(rst8_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    mux41_sel_t sel;
    logic [7:0] i0;
    logic [7:0] i1;
    logic [7:0] i2;
    logic [7:0] i3;
    logic [7:0] exp_comb;
    logic [7:0] exp_o;
    logic       exp_v;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick(input mux41_sel_t s, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c,
                                      input logic [7:0] d);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  initial begin
    logic       prev;
    logic       exp1;
    logic       chg;
    int         s;
    tests = 0;
    fails = 0;

    // Register expects the value before the edge; o follows one clock later
    vecs[0]  = '{1'b0, 1'b1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, RV8,   1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'd2, 8'h11, 8'h22, 8'h33, 8'h44, 8'h33, 8'h33, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h33, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h33, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, 8'h22, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, RV8,   1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'd1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h22, RV8,   1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd3, 8'h11, 8'h22, 8'h33, 8'hC3, 8'hC3, 8'hC3, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 8'hFF, 8'h00, 8'h33, 8'hC3, 8'hFF, 8'hFF, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'd1, 8'hFF, 8'h00, 8'h33, 8'hC3, 8'h00, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 8'hFF, 8'h00, 8'h5A, 8'hC3, 8'h5A, 8'h5A, 1'b1};

    rst1_n = 1'b0;
    rst8_n = 1'b0;
    if1.i0 = 1'b1; if1.i1 = 1'b0; if1.i2 = 1'b0; if1.i3 = 1'b0;
    if1.sel = 2'd0; if1.en = 1'b1;
    if8.i0 = 8'h00; if8.i1 = 8'h00; if8.i2 = 8'h00; if8.i3 = 8'h00;
    if8.sel = 2'd0; if8.en = 1'b0;

    // WIDTH=1: two reset clocks with en high; o_comb keeps tracking inputs
    tick();
    chk("w1_rst_o_1", {7'd0, if1.o}, 8'd0);
    chk("w1_rst_v_1", {7'd0, if1.o_valid}, 8'd0);
    chk("w1_rst_comb_sel0", {7'd0, if1.o_comb}, 8'd1);
    if1.sel = 2'd1;
    #1;
    chk("w1_rst_comb_sel1", {7'd0, if1.o_comb}, 8'd0);
    tick();
    chk("w1_rst_o_2", {7'd0, if1.o}, 8'd0);
    chk("w1_rst_v_2", {7'd0, if1.o_valid}, 8'd0);

    // WIDTH=1: sel sweep with i0..i3 = 1,0,0,0
    rst1_n = 1'b1;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if1.sel = mux41_sel_t'(k);
      exp1 = (k == 0) ? 1'b1 : 1'b0;
      #1;
      chk("w1_sweep_comb", {7'd0, if1.o_comb}, {7'd0, exp1});
      chk("w1_sweep_o_before_edge", {7'd0, if1.o}, {7'd0, prev});
      tick();
      chk("w1_sweep_o", {7'd0, if1.o}, {7'd0, exp1});
      chk("w1_sweep_v", {7'd0, if1.o_valid}, 8'd1);
      prev = exp1;
    end

    // WIDTH=8: table of capture / hold / mid-stream reset vectors
    for (int k = 0; k < 11; k++) begin
      rst8_n = vecs[k].rst_n;
      if8.en = vecs[k].en;
      if8.sel = vecs[k].sel;
      if8.i0 = vecs[k].i0;
      if8.i1 = vecs[k].i1;
      if8.i2 = vecs[k].i2;
      if8.i3 = vecs[k].i3;
      #1;
      chk($sformatf("w8_vec%0d_comb", k), if8.o_comb, vecs[k].exp_comb);
      tick();
      chk($sformatf("w8_vec%0d_o", k), if8.o, vecs[k].exp_o);
      chk($sformatf("w8_vec%0d_valid", k), {7'd0, if8.o_valid}, {7'd0, vecs[k].exp_v});
    end

    // WIDTH=8: inputs toggle at 5/10/15/20 time units with random sel
    if8.en = 1'b0;
    if8.i0 = 8'h0F; if8.i1 = 8'hF0; if8.i2 = 8'h3C; if8.i3 = 8'hC3;
    if8.sel = 2'd0;
    #1;
    chk("w8_toggle_init", if8.o_comb, 8'h0F);
    for (int t = 1; t <= 60; t++) begin
      chg = 1'b0;
      if (t % 5 == 0)  begin if8.i0 = ~if8.i0; chg = 1'b1; end
      if (t % 10 == 0) begin if8.i1 = ~if8.i1; end
      if (t % 15 == 0) begin if8.i2 = ~if8.i2; end
      if (t % 20 == 0) begin if8.i3 = ~if8.i3; end
      if (t % 5 == 0) begin
        s = $urandom_range(0, 3);
        if8.sel = mux41_sel_t'(s);
      end
      #1;
      if (chg)
        chk($sformatf("w8_toggle_t%0d", t), if8.o_comb,
            pick(if8.sel, if8.i0, if8.i1, if8.i2, if8.i3));
    end
    // en stayed low throughout, so the register must still hold the last capture
    chk("w8_toggle_hold_o", if8.o, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_mux_41
